// File: rtl/udp_mux_sched_pkg.sv
// rtl/udp_mux_sched_pkg.sv - shared types and helpers for the UDP TX mux scheduler
package udp_mux_sched_pkg;

  // Frame-level scheduler states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FRAME = 2'd2
  } sched_state_t;

  // Width of a saturating counter that must be able to hold stall_cycles itself
  function automatic int stall_cnt_width(input int stall_cycles);
    int w;
    w = $clog2(stall_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin / fixed-priority requester pick
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_round_robin,
  output logic [IW-1:0] o_winner,
  output logic          o_found
);

  logic [N-1:0] w_above;
  logic         w_any_above;

  // Rotating mode prefers the lowest requester above the last grant, else wraps to the lowest overall
  always_comb begin
    w_above = '0;
    for (int k = 0; k < N; k++) begin
      w_above[k] = i_req[k] && (k > int'(i_ptr));
    end
    w_any_above = |w_above;
    o_found     = |i_req;
    o_winner    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_round_robin && w_any_above) begin
        if (w_above[k]) o_winner = IW'(k);
      end else if (i_req[k]) begin
        o_winner = IW'(k);
      end
    end
  end

endmodule

// File: rtl/udp_mux_scheduler.sv
// rtl/udp_mux_scheduler.sv - frame-level enable/select scheduler for the UDP TX mux
module udp_mux_scheduler
  import udp_mux_sched_pkg::*;
#(
  parameter int S_COUNT      = 2,
  parameter int ROUND_ROBIN  = 1,
  parameter int STALL_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [S_COUNT-1:0]         req_hdr_valid,
  input  logic                       m_hdr_valid,
  input  logic                       m_hdr_ready,
  input  logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       m_tlast,
  output logic                       enable,
  output logic [$clog2(S_COUNT)-1:0] select,
  output logic [S_COUNT-1:0]         grant_onehot,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       stall_o
);

  localparam int                   SEL_W     = $clog2(S_COUNT);
  localparam int                   CNT_W     = stall_cnt_width(STALL_CYCLES);
  localparam logic [CNT_W-1:0]     STALL_MAX = CNT_W'(STALL_CYCLES);
  localparam logic [SEL_W-1:0]     LAST_IDX  = SEL_W'(S_COUNT - 1);
  localparam logic [S_COUNT-1:0]   ONE_HOT0  = S_COUNT'(1);

  sched_state_t       r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic               r_ptr_valid, w_ptr_valid_nxt;
  logic               r_enable, w_enable_nxt;
  logic [SEL_W-1:0]   r_select, w_select_nxt;
  logic [S_COUNT-1:0] r_grant, w_grant_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_stall_o, w_stall_o_nxt;
  logic               r_hdr_seen, w_hdr_seen_nxt;
  logic               r_last_seen, w_last_seen_nxt;
  logic [CNT_W-1:0]   r_stall_cnt, w_stall_cnt_nxt;

  logic               w_hdr_hs, w_last_hs, w_beat_hs, w_complete;
  logic [SEL_W-1:0]   w_ptr_eff, w_winner;
  logic               w_found;

  assign w_hdr_hs  = m_hdr_valid & m_hdr_ready;
  assign w_beat_hs = m_tvalid & m_tready;
  assign w_last_hs = w_beat_hs & m_tlast;

  // Before the first grant the pointer acts as "last index" so the first rotating pick starts at 0
  assign w_ptr_eff = r_ptr_valid ? r_ptr : LAST_IDX;

  rr_priority_pick #(
    .N  (S_COUNT),
    .IW (SEL_W)
  ) u_pick (
    .i_req         (req_hdr_valid),
    .i_ptr         (w_ptr_eff),
    .i_round_robin (ROUND_ROBIN != 0),
    .o_winner      (w_winner),
    .o_found       (w_found)
  );

  assign w_complete = (r_state != IDLE) &&
                      (r_hdr_seen  || w_hdr_hs) &&
                      (r_last_seen || w_last_hs);

  // Next-state, grant bookkeeping and stall watchdog; every output is a register fed from here
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_ptr_valid_nxt  = r_ptr_valid;
    w_enable_nxt     = r_enable;
    w_select_nxt     = r_select;
    w_grant_nxt      = r_grant;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_stall_o_nxt    = 1'b0;
    w_hdr_seen_nxt   = r_hdr_seen;
    w_last_seen_nxt  = r_last_seen;
    w_stall_cnt_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = GRANT;
          w_enable_nxt    = 1'b1;
          w_select_nxt    = w_winner;
          w_grant_nxt     = ONE_HOT0 << w_winner;
          w_busy_nxt      = 1'b1;
          w_ptr_nxt       = w_winner;
          w_ptr_valid_nxt = 1'b1;
        end
      end
      GRANT, FRAME: begin
        if (w_hdr_hs)  w_hdr_seen_nxt  = 1'b1;
        if (w_last_hs) w_last_seen_nxt = 1'b1;
        if (w_complete) begin
          w_state_nxt      = IDLE;
          w_enable_nxt     = 1'b0;
          w_busy_nxt       = 1'b0;
          w_grant_nxt      = '0;
          w_frame_done_nxt = 1'b1;
          w_hdr_seen_nxt   = 1'b0;
          w_last_seen_nxt  = 1'b0;
        end else if ((r_state == GRANT) && w_hdr_hs) begin
          w_state_nxt  = FRAME;
          w_enable_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_enable_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_grant_nxt  = '0;
      end
    endcase

    // Watchdog only runs once the header has gone out and the frame is still open
    if ((STALL_CYCLES != 0) && (r_state != IDLE) && r_hdr_seen && !w_complete && !w_beat_hs) begin
      if (r_stall_cnt != STALL_MAX) begin
        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        w_stall_o_nxt   = (r_stall_cnt + CNT_W'(1)) == STALL_MAX;
      end else begin
        w_stall_cnt_nxt = r_stall_cnt;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_ptr_valid  <= 1'b0;
      r_enable     <= 1'b0;
      r_select     <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_stall_o    <= 1'b0;
      r_hdr_seen   <= 1'b0;
      r_last_seen  <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_ptr_valid  <= w_ptr_valid_nxt;
      r_enable     <= w_enable_nxt;
      r_select     <= w_select_nxt;
      r_grant      <= w_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_stall_o    <= w_stall_o_nxt;
      r_hdr_seen   <= w_hdr_seen_nxt;
      r_last_seen  <= w_last_seen_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
    end
  end

  assign enable       = r_enable;
  assign select       = r_select;
  assign grant_onehot = r_grant;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign stall_o      = r_stall_o;

endmodule

// File: tb/tb_udp_mux_scheduler.sv
// tb/tb_udp_mux_scheduler.sv - self-checking bench for udp_mux_scheduler
module tb_udp_mux_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       hv, hr, tv, tr, tl;

  logic       en_a, busy_a, done_a, stall_a;
  logic [1:0] sel_a;
  logic [3:0] gnt_a;
  logic       en_b, busy_b, done_b, stall_b;
  logic [1:0] sel_b;
  logic [3:0] gnt_b;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_last  = 3;
  int fx_last  = 0;

  always #5 clk = ~clk;

  udp_mux_scheduler #(.S_COUNT(4), .ROUND_ROBIN(1), .STALL_CYCLES(8)) u_rr (
    .clk(clk), .reset(reset), .req_hdr_valid(req),
    .m_hdr_valid(hv), .m_hdr_ready(hr), .m_tvalid(tv), .m_tready(tr), .m_tlast(tl),
    .enable(en_a), .select(sel_a), .grant_onehot(gnt_a), .busy(busy_a),
    .frame_done(done_a), .stall_o(stall_a)
  );

  udp_mux_scheduler #(.S_COUNT(4), .ROUND_ROBIN(0), .STALL_CYCLES(8)) u_fx (
    .clk(clk), .reset(reset), .req_hdr_valid(req),
    .m_hdr_valid(hv), .m_hdr_ready(hr), .m_tvalid(tv), .m_tready(tr), .m_tlast(tl),
    .enable(en_b), .select(sel_b), .grant_onehot(gnt_b), .busy(busy_b),
    .frame_done(done_b), .stall_o(stall_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hv = 1'b0; hr = 1'b0; tv = 1'b0; tr = 1'b0; tl = 1'b0;
  endtask

  function automatic int pick_rr(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  function automatic int pick_fx(input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) return k;
    end
    return 0;
  endfunction

  task automatic run_frame(input logic [3:0] mask, input int hdr_cyc, input int last_cyc,
                           input int force_beat, input int prob, input string tag);
    int   ea, eb, done_cyc, cnt;
    logic beat, es, live;
    req = mask;
    bus_idle();
    ea = pick_rr(mask, rr_last);
    eb = pick_fx(mask);
    tick();
    check({tag, ":grant_en_a"},   32'(en_a),   1);
    check({tag, ":grant_en_b"},   32'(en_b),   1);
    check({tag, ":grant_sel_a"},  32'(sel_a),  ea);
    check({tag, ":grant_sel_b"},  32'(sel_b),  eb);
    check({tag, ":grant_oh_a"},   32'(gnt_a),  1 << ea);
    check({tag, ":grant_oh_b"},   32'(gnt_b),  1 << eb);
    check({tag, ":grant_busy_a"}, 32'(busy_a), 1);
    check({tag, ":grant_done_a"}, 32'(done_a), 0);
    rr_last  = ea;
    fx_last  = eb;
    done_cyc = (hdr_cyc > last_cyc) ? hdr_cyc : last_cyc;
    cnt      = 0;
    for (int c = 0; c <= done_cyc; c++) begin
      beat = (c == last_cyc) || (c == force_beat) ||
             ((c < last_cyc) && ($urandom_range(0, 99) < prob));
      hr = (c == hdr_cyc);
      hv = (c == hdr_cyc) ? 1'b1 : ((c < hdr_cyc) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (beat) begin
        tv = 1'b1; tr = 1'b1; tl = (c == last_cyc);
      end else begin
        tv = 1'($urandom_range(0, 1));
        tr = tv ? 1'b0 : 1'($urandom_range(0, 1));
        tl = 1'($urandom_range(0, 1));
      end
      tick();
      es = 1'b0;
      if (c > hdr_cyc && c != done_cyc) begin
        if (beat) cnt = 0;
        else if (cnt < 8) begin
          cnt++;
          es = (cnt == 8);
        end
      end else begin
        cnt = 0;
      end
      live = (c != done_cyc);
      check({tag, ":done_a"},  32'(done_a),  32'(c == done_cyc));
      check({tag, ":done_b"},  32'(done_b),  32'(c == done_cyc));
      check({tag, ":en_a"},    32'(en_a),    32'(c < hdr_cyc));
      check({tag, ":en_b"},    32'(en_b),    32'(c < hdr_cyc));
      check({tag, ":busy_a"},  32'(busy_a),  32'(live));
      check({tag, ":busy_b"},  32'(busy_b),  32'(live));
      check({tag, ":sel_a"},   32'(sel_a),   ea);
      check({tag, ":sel_b"},   32'(sel_b),   eb);
      check({tag, ":oh_a"},    32'(gnt_a),   live ? (1 << ea) : 0);
      check({tag, ":oh_b"},    32'(gnt_b),   live ? (1 << eb) : 0);
      check({tag, ":stall_a"}, 32'(stall_a), 32'(es));
      check({tag, ":stall_b"}, 32'(stall_b), 32'(es));
    end
    bus_idle();
  endtask

  task automatic idle_cycles(input int n, input string tag);
    req = 4'b0000;
    for (int i = 0; i < n; i++) begin
      hv = 1'($urandom_range(0, 1));
      hr = hv;
      tv = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      tl = 1'($urandom_range(0, 1));
      tick();
      check({tag, ":idle_en"},   32'(en_a),   0);
      check({tag, ":idle_busy"}, 32'(busy_a), 0);
      check({tag, ":idle_oh"},   32'(gnt_a),  0);
      check({tag, ":idle_done"}, 32'(done_a), 0);
      check({tag, ":idle_sel_a"}, 32'(sel_a), rr_last);
      check({tag, ":idle_sel_b"}, 32'(sel_b), fx_last);
      check({tag, ":idle_busy_b"}, 32'(busy_b), 0);
    end
    bus_idle();
  endtask

  initial begin
    logic [3:0] m;
    int         h, l;

    reset = 1'b1;
    req   = 4'b0000;
    bus_idle();
    tick();
    tick();
    check("rst:en",    32'(en_a),    0);
    check("rst:sel",   32'(sel_a),   0);
    check("rst:oh",    32'(gnt_a),   0);
    check("rst:busy",  32'(busy_a),  0);
    check("rst:done",  32'(done_a),  0);
    check("rst:stall", 32'(stall_a), 0);
    reset = 1'b0;

    // Single requester, header one cycle after grant, last beat a few cycles later
    run_frame(4'b0001, 1, 6, 4, 0, "t1");

    // All requesting: rotating gives 0,1,2 after 0 is consumed once more; fixed stays at 0
    idle_cycles(2, "t2pre");
    rr_last = 3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fx_last = 0;
    run_frame(4'b1111, 0, 3, -1, 50, "t2a");
    run_frame(4'b1111, 1, 2, -1, 50, "t2b");
    run_frame(4'b1111, 2, 4, -1, 50, "t2c");
    check("t2:rr_third",  32'(sel_a), 2);
    check("t2:fx_third",  32'(sel_b), 0);
    idle_cycles(3, "t2post");

    // One-beat frame: header and last handshake in the same cycle
    run_frame(4'b1010, 2, 2, -1, 0, "t3");
    // Payload last before the header handshake
    run_frame(4'b0110, 5, 2, -1, 40, "t4");
    // Watchdog: long gap, a single beat clears it, then a second long gap
    run_frame(4'b0100, 1, 25, 11, 0, "t5");
    idle_cycles(1, "t5post");

    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      h = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) l = $urandom_range(0, h);
      else                           l = h + $urandom_range(0, 8);
      run_frame(m, h, l, -1, $urandom_range(30, 90), "rnd");
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), "rnd_idle");
    end

    // Reset mid-frame with requests pending
    req = 4'b0110;
    tick();
    hv = 1'b1; hr = 1'b1;
    tick();
    bus_idle();
    req = 4'b1111;
    tick();
    check("t6:in_frame_en",   32'(en_a),   0);
    check("t6:in_frame_busy", 32'(busy_a), 1);
    reset = 1'b1;
    tick();
    check("t6:rst_en_a",   32'(en_a),   0);
    check("t6:rst_sel_a",  32'(sel_a),  0);
    check("t6:rst_oh_a",   32'(gnt_a),  0);
    check("t6:rst_busy_a", 32'(busy_a), 0);
    check("t6:rst_done_a", 32'(done_a), 0);
    check("t6:rst_stall_a", 32'(stall_a), 0);
    check("t6:rst_sel_b",  32'(sel_b),  0);
    check("t6:rst_busy_b", 32'(busy_b), 0);
    reset   = 1'b0;
    rr_last = 3;
    fx_last = 0;
    run_frame(4'b1111, 0, 3, -1, 50, "t6");
    check("t6:regrant_idx0", 32'(sel_a), 0);
    idle_cycles(2, "end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
